data_mem_arbiter: RTL and testbench

//  Shares the single-port 64x16 DataMemory between two requesters: port 0 (pipeline MEM stage)
//  and port 1 (loader/DMA). Each cycle it picks one winner and drives the memory's A/WD/WE.
//  For reads, it returns the memory's registered read data to the winner one cycle later.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_grant_fsm.sv | 89 ++++++++
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the DataMemory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEPTH_DEF     = 64;
  localparam int unsigned AW_DEF        = 16;
  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned MAX_BURST_DEF = 4;

  // Arbiter ownership state: nobody, or the port that won the previous cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Requester index: 0 = pipeline MEM stage, 1 = loader/DMA
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_e;

endpackage

// File: rtl/arb_grant_fsm.sv
// Round-robin grant FSM with a burst limit for two requesters.
// Produces a combinational one-hot (or zero) grant from the current requests.
module arb_grant_fsm
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam int unsigned   CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  port_idx_e       last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  port_idx_e       own, other, win;
  logic            own_vld, own_req, oth_req, win_vld;

  // Winner selection and next-state computation
  always_comb begin
    own_vld = (state_q != ST_IDLE);
    own     = (state_q == ST_OWN1) ? PORT1 : PORT0;
    other   = (own == PORT1) ? PORT0 : PORT1;
    own_req = (own == PORT1) ? req1_i : req0_i;
    oth_req = (own == PORT1) ? req0_i : req1_i;
    win_vld = 1'b0;
    win     = PORT0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (!own_vld) begin
      if (req0_i && req1_i) begin
        win_vld = 1'b1;
        win     = (last_q == PORT1) ? PORT0 : PORT1;
      end else if (req0_i) begin
        win_vld = 1'b1;
        win     = PORT0;
      end else if (req1_i) begin
        win_vld = 1'b1;
        win     = PORT1;
      end
    end else if (own_req) begin
      win_vld = 1'b1;
      win     = ((cnt_q == CNT_MAX) && oth_req) ? other : own;
    end else if (oth_req) begin
      win_vld = 1'b1;
      win     = other;
    end

    if (!win_vld) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = (win == PORT1) ? ST_OWN1 : ST_OWN0;
      last_d  = win;
      // Count stays saturated while the owner keeps the grant past expiry
      if (own_vld && (win == own)) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end

    gnt0_o = rst_ni & win_vld & (win == PORT0);
    gnt1_o = rst_ni & win_vld & (win == PORT1);
  end

  // State, last winner and burst counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= PORT1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory.
// Optional feature: define ARB_PERF_CNT_EN to add the PERF_CONFLICT counter output.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          P0_REQ,
  input  logic          P0_WE,
  input  logic [AW-1:0] P0_A,
  input  logic [DW-1:0] P0_WD,
  input  logic          P1_REQ,
  input  logic          P1_WE,
  input  logic [AW-1:0] P1_A,
  input  logic [DW-1:0] P1_WD,
  output logic          P0_GNT,
  output logic          P1_GNT,
  output logic          P0_RVALID,
  output logic          P1_RVALID,
  output logic [DW-1:0] P0_RD,
  output logic [DW-1:0] P1_RD,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_WD,
  output logic          M_WE,
  input  logic [DW-1:0] M_RD,
  output logic          ERR
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   PERF_CONFLICT
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic          gnt_any, sel_we, in_range;
  logic [AW-1:0] sel_a;
  logic [DW-1:0] sel_wd;

  logic [AW-1:0] ma_q, ma_d;
  logic [DW-1:0] mwd_q, mwd_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          rzero_q, rzero_d;
  logic          err_q, err_d;

  arb_grant_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .req0_i (P0_REQ),
    .req1_i (P1_REQ),
    .gnt0_o (P0_GNT),
    .gnt1_o (P1_GNT)
  );

  // Winner mux onto the memory port; address/data hold when nobody is granted
  always_comb begin
    gnt_any  = P0_GNT | P1_GNT;
    sel_a    = P1_GNT ? P1_A  : P0_A;
    sel_wd   = P1_GNT ? P1_WD : P0_WD;
    sel_we   = P1_GNT ? P1_WE : P0_WE;
    in_range = ({1'b0, sel_a} < DEPTH_W);

    M_A   = gnt_any ? sel_a  : ma_q;
    M_WD  = gnt_any ? sel_wd : mwd_q;
    M_WE  = gnt_any & sel_we & in_range;
    ma_d  = M_A;
    mwd_d = M_WD;

    rvalid0_d = P0_GNT & ~P0_WE;
    rvalid1_d = P1_GNT & ~P1_WE;
    rzero_d   = gnt_any & ~sel_we & ~in_range;
    err_d     = gnt_any & ~in_range;

    P0_RVALID = rvalid0_q;
    P1_RVALID = rvalid1_q;
    P0_RD     = (rvalid0_q & ~rzero_q) ? M_RD : '0;
    P1_RD     = (rvalid1_q & ~rzero_q) ? M_RD : '0;
    ERR       = err_q;
  end

  // Held memory drive, read-return pipe and error pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ma_q      <= '0;
      mwd_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rzero_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ma_q      <= ma_d;
      mwd_q     <= mwd_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rzero_q   <= rzero_d;
      err_q     <= err_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of cycles where both ports request
  always_comb begin
    perf_d = perf_q;
    if (P0_REQ && P1_REQ && (perf_q != '1)) begin
      perf_d = perf_q + 16'd1;
    end
    PERF_CONFLICT = perf_q;
  end

  // Conflict counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural DataMemory
// and a run-length based arbitration reference model.
module tb_data_mem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 64;

  logic        CLK, RST_N;
  logic        P0_REQ, P0_WE, P1_REQ, P1_WE;
  logic [15:0] P0_A, P0_WD, P1_A, P1_WD;
  logic        P0_GNT, P1_GNT, P0_RVALID, P1_RVALID;
  logic [15:0] P0_RD, P1_RD;
  logic [15:0] M_A, M_WD, M_RD;
  logic        M_WE, ERR;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] PERF_CONFLICT;
`endif

  data_mem_arbiter #(
    .DEPTH     (64),
    .AW        (16),
    .DW        (16),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .P0_REQ    (P0_REQ),
    .P0_WE     (P0_WE),
    .P0_A      (P0_A),
    .P0_WD     (P0_WD),
    .P1_REQ    (P1_REQ),
    .P1_WE     (P1_WE),
    .P1_A      (P1_A),
    .P1_WD     (P1_WD),
    .P0_GNT    (P0_GNT),
    .P1_GNT    (P1_GNT),
    .P0_RVALID (P0_RVALID),
    .P1_RVALID (P1_RVALID),
    .P0_RD     (P0_RD),
    .P1_RD     (P1_RD),
    .M_A       (M_A),
    .M_WD      (M_WD),
    .M_WE      (M_WE),
    .M_RD      (M_RD),
    .ERR       (ERR)
`ifdef ARB_PERF_CNT_EN
    ,
    .PERF_CONFLICT (PERF_CONFLICT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural DataMemory: write on negedge, registered read on posedge
  logic [15:0] mem [64];
  logic        pre_en;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;

  always @(negedge CLK) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (M_WE) mem[M_A[5:0]] <= M_WD;
  end

  always @(posedge CLK) M_RD <= mem[M_A[5:0]];

  // Reference model state
  int          checks = 0;
  int          errors = 0;
  logic [15:0] refmem [64];
  logic        r_req [2];
  logic        r_we  [2];
  logic [15:0] r_a   [2];
  logic [15:0] r_wd  [2];
  int          mode;       // 0: drop request after grant, 1: hold, 2: random traffic
  int          prev_w;     // winner of previous cycle, -1 if none
  int          run;        // consecutive grants to prev_w
  int          last_m;     // most recent winner
  int          lastwin;    // winner of the cycle just checked
  logic        exp_rv [2];
  logic [15:0] exp_rd [2];
  logic        exp_err;
  logic [15:0] hold_a, hold_wd;
  int          perf_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    prev_w  = -1;
    run     = 0;
    last_m  = 1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_err = 1'b0;
    hold_a  = '0;
    hold_wd = '0;
    perf_m  = 0;
    for (int p = 0; p < 2; p++) r_req[p] = 1'b0;
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    P0_REQ = 1'b1;
    P0_WE  = 1'b0;
    P0_A   = 16'd1;
    P1_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    chk("rst_gnt0", P0_GNT, 0);
    chk("rst_gnt1", P1_GNT, 0);
    chk("rst_rv0", P0_RVALID, 0);
    chk("rst_rv1", P1_RVALID, 0);
    chk("rst_rd0", P0_RD, 0);
    chk("rst_rd1", P1_RD, 0);
    chk("rst_err", ERR, 0);
    chk("rst_ma", M_A, 0);
    chk("rst_mwd", M_WD, 0);
    chk("rst_mwe", M_WE, 0);
    P0_REQ = 1'b0;
    RST_N  = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive requests, check the DUT against the model, advance the model
  task automatic cyc();
    int          w;
    logic [15:0] wa;
    @(posedge CLK);
    #1;
    P0_REQ = r_req[0]; P0_WE = r_we[0]; P0_A = r_a[0]; P0_WD = r_wd[0];
    P1_REQ = r_req[1]; P1_WE = r_we[1]; P1_A = r_a[1]; P1_WD = r_wd[1];
    #2;
    w = -1;
    if (r_req[0] && r_req[1]) begin
      if (prev_w < 0)            w = 1 - last_m;
      else if (run >= MAX_BURST) w = 1 - prev_w;
      else                       w = prev_w;
    end else if (r_req[0]) w = 0;
    else if (r_req[1]) w = 1;
    lastwin = w;

    chk("gnt0", P0_GNT, (w == 0) ? 1 : 0);
    chk("gnt1", P1_GNT, (w == 1) ? 1 : 0);
    chk("rv0", P0_RVALID, exp_rv[0]);
    chk("rv1", P1_RVALID, exp_rv[1]);
    if (exp_rv[0]) chk("rd0", P0_RD, exp_rd[0]);
    if (exp_rv[1]) chk("rd1", P1_RD, exp_rd[1]);
    chk("err", ERR, exp_err);
`ifdef ARB_PERF_CNT_EN
    chk("perf", PERF_CONFLICT, perf_m);
`endif
    if (w >= 0) begin
      wa = r_a[w];
      chk("ma", M_A, wa);
      chk("mwd", M_WD, r_wd[w]);
      chk("mwe", M_WE, (r_we[w] && wa < DEPTH) ? 1 : 0);
    end else begin
      chk("ma_hold", M_A, hold_a);
      chk("mwd_hold", M_WD, hold_wd);
      chk("mwe_idle", M_WE, 0);
    end

    if (r_req[0] && r_req[1]) perf_m++;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_err   = 1'b0;
    if (w >= 0) begin
      wa = r_a[w];
      if (wa < DEPTH) begin
        if (r_we[w]) refmem[wa[5:0]] = r_wd[w];
      end else begin
        exp_err = 1'b1;
      end
      if (!r_we[w]) begin
        exp_rv[w] = 1'b1;
        exp_rd[w] = (wa < DEPTH) ? refmem[wa[5:0]] : 16'h0000;
      end
      hold_a  = wa;
      hold_wd = r_wd[w];
      run     = (w == prev_w) ? run + 1 : 1;
      prev_w  = w;
      last_m  = w;
      if (mode != 1) r_req[w] = 1'b0;
    end else begin
      prev_w = -1;
      run    = 0;
    end
    if (mode == 2) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] && ($urandom_range(0, 9) < 8)) begin
          r_req[p] = 1'b1;
          r_we[p]  = 1'($urandom_range(0, 1));
          r_a[p]   = ($urandom_range(0, 7) == 0) ? 16'(64 + $urandom_range(0, 300))
                                                  : 16'($urandom_range(0, 63));
          r_wd[p]  = 16'($urandom);
        end
      end
    end
  endtask

  initial begin
    int          order [10];
    int          exp_order [10];
    logic [15:0] v0;
    logic        seen;

    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    RST_N  = 1'b0;
    pre_en = 1'b0;
    pre_a  = '0;
    pre_d  = '0;
    P0_REQ = 1'b0; P0_WE = 1'b0; P0_A = '0; P0_WD = '0;
    P1_REQ = 1'b0; P1_WE = 1'b0; P1_A = '0; P1_WD = '0;
    mode = 0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_a[p] = '0; r_wd[p] = '0;
    end
    model_reset();

    // Preload memory while reset is held
    #1;
    pre_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_a     = 6'(i);
      pre_d     = (i == 5) ? 16'd7 : 16'($urandom);
      refmem[i] = pre_d;
      @(negedge CLK);
      #1;
    end
    pre_en = 1'b0;
    do_reset();

    // Single read of address 5
    mode = 0;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 16'd5; r_wd[0] = 16'h0;
    cyc();
    chk("t1_gnt", P0_GNT, 1);
    cyc();
    chk("t1_rvalid", P0_RVALID, 1);
    chk("t1_rd", P0_RD, 16'd7);

    // Both ports requesting for 10 cycles from idle
    do_reset();
    mode = 1;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 16'd10; r_wd[0] = 16'h1111;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_a[1] = 16'd20; r_wd[1] = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      cyc();
      order[i] = lastwin;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("t2_order%0d", i), order[i], exp_order[i]);
    mode = 0;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    cyc();
`ifdef ARB_PERF_CNT_EN
    chk("t2_perf", PERF_CONFLICT, 10);
`endif

    // Write from P1 then immediate read from P0 of the same word
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_a[1] = 16'd3; r_wd[1] = 16'h1234;
    cyc();
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 16'd3;
    cyc();
    cyc();
    chk("t3_rvalid", P0_RVALID, 1);
    chk("t3_rd", P0_RD, 16'h1234);

    // Out-of-range write and read
    v0 = refmem[0];
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_a[0] = 16'd64; r_wd[0] = 16'hBEEF;
    cyc();
    chk("t4_mwe", M_WE, 0);
    cyc();
    chk("t4_err_pulse", ERR, 1);
    cyc();
    chk("t4_err_clear", ERR, 0);
    chk("t4_mem_unchanged", mem[0], v0);
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_a[1] = 16'd70;
    cyc();
    cyc();
    chk("t4_rvalid", P1_RVALID, 1);
    chk("t4_rd_zero", P1_RD, 0);
    chk("t4_err_rd", ERR, 1);

    // Reset asserted in the cycle after a read grant
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 16'd5;
    cyc();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t5_rvalid_killed", P0_RVALID, 0);
    do_reset();
    repeat (3) begin
      cyc();
      chk("t5_no_rvalid", P0_RVALID, 0);
    end

    // P1 alone for 8 cycles, then P0 joins
    mode = 1;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_a[1] = 16'd40; r_wd[1] = 16'h0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("t6_p1_gnt%0d", i), P1_GNT, 1);
    end
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 16'd41; r_wd[0] = 16'h0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!seen) begin
        cyc();
        if (lastwin == 0) seen = 1'b1;
      end
    end
    chk("t6_p0_within4", seen, 1);
    mode = 0;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    cyc();

    // Random traffic against the model
    mode = 2;
    repeat (600) cyc();
    mode = 0;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
